// File: rtl/scan_mux.sv
// Channel scan multiplexer: DIRECT / AUTO / HOLD selection with a 1-deep output register.
// Optional parity output out_par enabled by defining SCAN_MUX_PARITY_EN.
module scan_mux #(
    parameter int DATA_W = 8,
    parameter int CH = 32,
    localparam int SEL_W = $clog2(CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH*DATA_W-1:0] din,
    input  logic [SEL_W-1:0]     sel,
    input  logic [1:0]           mode,
    input  logic [CH-1:0]        ch_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [SEL_W-1:0]     out_ch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 scan_done,
`ifdef SCAN_MUX_PARITY_EN
    output logic                 out_par,
`endif
    output logic                 err
);

    typedef enum logic [1:0] {
        S_DIRECT,
        S_AUTO,
        S_HOLD
    } state_t;

    localparam logic [SEL_W:0]   CH_N = (SEL_W+1)'(CH);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(CH - 1);

    state_t             st;
    state_t             nxt_st;
    logic [SEL_W-1:0]   ptr;
    logic               acc;
    logic               sel_ok;
    logic [DATA_W-1:0]  direct_word;
    logic [DATA_W-1:0]  auto_word;
    logic [SEL_W-1:0]   lo_all;
    logic [SEL_W-1:0]   lo_hi;
    logic               any_en;
    logic               hit_hi;
    logic [SEL_W-1:0]   c;
    logic [SEL_W-1:0]   c_next;
    logic               more;
    logic               load;
    logic [DATA_W-1:0]  load_data;
    logic [SEL_W-1:0]   load_ch;

    assign in_ready = (st != S_HOLD) && (!out_valid || out_ready);
    assign acc      = in_valid && in_ready;
    assign sel_ok   = {1'b0, sel} < CH_N;

    // Decode the mode pins into the state that takes effect next cycle
    always_comb begin
        case (mode)
            2'b00:   nxt_st = S_DIRECT;
            2'b01:   nxt_st = S_AUTO;
            default: nxt_st = S_HOLD;
        endcase
    end

    // Word addressed by sel; out-of-range indices select nothing
    always_comb begin
        direct_word = '0;
        for (int k = 0; k < CH; k++) begin
            if (sel == SEL_W'(k)) direct_word = din[k*DATA_W +: DATA_W];
        end
    end

    // Find the first enabled channel at or after ptr, wrapping to the lowest enabled one
    always_comb begin
        lo_all = '0;
        lo_hi  = '0;
        any_en = 1'b0;
        hit_hi = 1'b0;
        for (int j = CH - 1; j >= 0; j--) begin
            if (ch_en[j]) begin
                lo_all = SEL_W'(j);
                any_en = 1'b1;
                if (SEL_W'(j) >= ptr) begin
                    lo_hi  = SEL_W'(j);
                    hit_hi = 1'b1;
                end
            end
        end
        c = hit_hi ? lo_hi : lo_all;
    end

    // Chosen AUTO word, whether c is the last enabled channel, and the following pointer
    always_comb begin
        auto_word = '0;
        more      = 1'b0;
        for (int j = 0; j < CH; j++) begin
            if (c == SEL_W'(j)) auto_word = din[j*DATA_W +: DATA_W];
            if (ch_en[j] && (SEL_W'(j) > c)) more = 1'b1;
        end
        c_next = (c == LAST) ? '0 : c + 1'b1;
    end

    // Select what an accept loads into the output register
    always_comb begin
        load      = acc && ((st != S_AUTO) || any_en);
        load_data = '0;
        load_ch   = sel;
        if (st == S_AUTO) begin
            load_data = auto_word;
            load_ch   = c;
        end else if (sel_ok) begin
            load_data = direct_word;
        end
    end

    // Mode state, scan pointer, output register and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= S_DIRECT;
            ptr       <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            scan_done <= 1'b0;
            err       <= 1'b0;
`ifdef SCAN_MUX_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else begin
            st  <= nxt_st;
            err <= acc && ((st == S_AUTO) ? !any_en : !sel_ok);
            if ((st != S_AUTO) && (nxt_st == S_AUTO)) begin
                ptr <= '0;
            end else if (load && (st == S_AUTO)) begin
                ptr <= c_next;
            end
            if (load) begin
                out_data  <= load_data;
                out_ch    <= load_ch;
                out_valid <= 1'b1;
                scan_done <= (st == S_AUTO) && !more;
`ifdef SCAN_MUX_PARITY_EN
                out_par   <= ^load_data;
`endif
            end else if (acc || (out_valid && out_ready)) begin
                out_valid <= 1'b0;
                scan_done <= 1'b0;
            end
        end
    end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of each channel word.
REQ-002 The block SHALL have parameter CH, default 32, giving the channel count (2..256), with SEL_W = clog2(CH) derived internally.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port din, input, CH*DATA_W bits: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-006 The block SHALL have port sel, input, SEL_W bits: channel index used in DIRECT mode.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 = DIRECT, 01 = AUTO, 10 = HOLD, 11 = HOLD.
REQ-008 The block SHALL have port ch_en, input, CH bits: AUTO-mode enable mask, where bit k = 1 means channel k is scanned.
REQ-009 The block SHALL have port in_valid, input, 1 bit: a sample request.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the request can be accepted this cycle.
REQ-011 The block SHALL have port out_data, output, DATA_W bits: the registered selected word.
REQ-012 The block SHALL have port out_ch, output, SEL_W bits: the channel index of out_data.
REQ-013 The block SHALL have port out_valid, output, 1 bit; port out_ready, input, 1 bit: the output handshake.
REQ-014 The block SHALL have port scan_done, output, 1 bit: marks the last enabled channel of an AUTO pass.
REQ-015 The block SHALL have port err, output, 1 bit: a one-cycle error pulse.

Function
REQ-016 State register st ∈ {S_DIRECT, S_AUTO, S_HOLD} SHALL load the decoded mode every cycle; behaviour in cycle n SHALL use st, not mode.
REQ-017 Transition into S_AUTO from any other state SHALL reset scan pointer ptr to 0; ptr SHALL hold value in all other states.
REQ-018 in_ready SHALL equal (st != S_HOLD) && (!out_valid || out_ready), combinationally.
REQ-019 An accept (acc) SHALL occur when in_valid && in_ready; output registers SHALL update on the same edge (latency 1 cycle from accept to out_valid).
REQ-020 In S_DIRECT with acc and sel < CH: out_data <= din[sel], out_ch <= sel, out_valid <= 1.
REQ-021 In S_DIRECT with acc and sel >= CH: out_data <= 0, out_ch <= sel, out_valid <= 1, err pulses 1 cycle.
REQ-022 In S_AUTO with acc: chosen channel c = first index >= ptr with ch_en[c] = 1, searching with wrap CH-1 -> 0; out_data <= din[c], out_ch <= c, out_valid <= 1, ptr <= (c+1) mod CH.
REQ-023 In S_AUTO, scan_done SHALL be registered with the output and equal 1 iff no enabled channel index > c exists.
REQ-024 In S_AUTO with acc and ch_en = 0: no output is produced, out_valid is unchanged-or-cleared per REQ-025, err pulses 1 cycle, and ptr is unchanged.
REQ-025 When out_valid && out_ready && !acc, out_valid SHALL clear to 0 and scan_done SHALL clear to 0.
REQ-026 While out_valid && !out_ready (stall), out_data, out_ch, out_valid and scan_done SHALL be held stable.
REQ-027 In S_HOLD, no accept SHALL occur; a pending output SHALL still complete its handshake.
REQ-028 Changes to din, sel or ch_en without an accept SHALL NOT alter the outputs.

Reset
REQ-029 On rst_n = 0, asynchronously: out_data = 0, out_ch = 0, out_valid = 0, scan_done = 0, err = 0, ptr = 0, st = S_DIRECT.
REQ-030 Reset asserted mid-transfer SHALL discard the pending output; the first accept after release SHALL behave as from power-up.

Configuration
REQ-031 Macro SCAN_MUX_PARITY_EN defined: extra output port out_par (1 bit, registered with out_data) SHALL equal the XOR of all out_data bits; its reset value is 0 and it is held during a stall.
REQ-032 Macro SCAN_MUX_PARITY_EN undefined: port out_par and its logic SHALL be absent; all other behaviour is identical.

Verification (CH=32, DATA_W=8)
REQ-033 DIRECT, din[5] = 8'hA5, sel = 5, in_valid pulse, out_ready = 1 -> next cycle out_data = A5, out_ch = 5, out_valid = 1 for 1 cycle.
REQ-034 AUTO, ch_en = 32'h8000_0011, 4 accepts -> out_ch sequence 0, 4, 31, 0; scan_done = 1 only with ch 31.
REQ-035 Stall: out_ready = 0 for 3 cycles with in_valid = 1 and din changing -> outputs held, in_ready = 0, no ptr advance.
REQ-036 AUTO with ch_en = 0, accept -> err pulse for 1 cycle, out_valid remains 0.
REQ-037 mode = HOLD while in_valid = 1 -> in_ready = 0; switching to AUTO -> first output is ch 0 regardless of prior ptr.
REQ-038 rst_n low while out_valid = 1 mid-stall -> all outputs 0 immediately; with SCAN_MUX_PARITY_EN, out_par = 1 for out_data = 8'h07.
